seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller and double-buffered frame store for an 8-digit multiplexed 7-segment display.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl #(
  parameter int F_CLK     = 50000000,
  parameter int F_SCAN    = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       commit,
  output logic       commit_pending,
  output logic       frame_done,
  output logic [2:0] cs_pointer,
  output logic [4:0] dig_ctrl,
  output logic       blank
);

  localparam int DIV = F_CLK / F_SCAN;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_t;

  localparam phase_t PH_SLOT_START = (BLANK_CYC > 0) ? PH_BLANK : PH_SHOW;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  // An all-zero buffer suppresses digit 0, so the display starts dark.
  localparam logic RST_BLANK = 1'b1;
`else
  localparam logic RST_BLANK = (BLANK_CYC > 0);
`endif

  logic [4:0]    shadow_mem [8];
  logic [4:0]    active_mem [8];
  logic [4:0]    active_next [8];

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic [2:0]    ptr_reg;
  logic [2:0]    ptr_next;
  phase_t        phase_reg;
  phase_t        phase_next;
  logic          pending_reg;
  logic          frame_done_reg;
  logic [4:0]    dig_reg;
  logic          blank_reg;
  logic          blank_next;

  logic          slot_end;
  logic          frame_end;
  logic          do_copy;

  always_comb begin
    slot_end  = (cnt_reg == CNT_LAST);
    frame_end = slot_end && (ptr_reg == 3'd7);
    do_copy   = frame_end && pending_reg;
    cnt_next  = slot_end ? '0 : cnt_reg + CW'(1);
    ptr_next  = slot_end ? ptr_reg + 3'd1 : ptr_reg;
  end

  // Contents the active buffer will hold after this edge; the copy sees shadow before any same-edge write.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_active_next
      assign active_next[gi] = do_copy ? shadow_mem[gi] : active_mem[gi];
    end
  endgenerate

  always_comb begin
    phase_next = phase_reg;
    if (slot_end)
      phase_next = PH_SLOT_START;
    else if (phase_reg == PH_BLANK && cnt_next >= BLANK_LIM)
      phase_next = PH_SHOW;
  end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic [7:0] zero_vec;
  logic [7:0] supp_vec;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_zero
      assign zero_vec[gi] = (active_next[gi] == 5'h00);
    end
    assign supp_vec[0] = zero_vec[0];
    for (genvar gi = 1; gi < 7; gi++) begin : g_supp
      assign supp_vec[gi] = supp_vec[gi-1] & zero_vec[gi];
    end
    assign supp_vec[7] = 1'b0;
  endgenerate

  always_comb begin
    blank_next = (phase_next == PH_BLANK) || supp_vec[ptr_next];
  end
`else
  always_comb begin
    blank_next = (phase_next == PH_BLANK);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      ptr_reg        <= 3'd0;
      phase_reg      <= PH_SLOT_START;
      pending_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      dig_reg        <= 5'h00;
      blank_reg      <= RST_BLANK;
      for (int i = 0; i < 8; i++) begin
        shadow_mem[i] <= 5'h00;
        active_mem[i] <= 5'h00;
      end
    end else begin
      cnt_reg        <= cnt_next;
      ptr_reg        <= ptr_next;
      phase_reg      <= phase_next;
      blank_reg      <= blank_next;
      frame_done_reg <= frame_end;
      if (slot_end)
        dig_reg <= active_next[ptr_next];
      // A commit landing on the applying boundary is absorbed into that copy.
      if (do_copy)
        pending_reg <= 1'b0;
      else if (commit)
        pending_reg <= 1'b1;
      for (int i = 0; i < 8; i++)
        active_mem[i] <= active_next[i];
      if (wr_en)
        shadow_mem[wr_addr] <= wr_data;
    end
  end

  assign cs_pointer     = ptr_reg;
  assign dig_ctrl       = dig_reg;
  assign blank          = blank_reg;
  assign frame_done     = frame_done_reg;
  assign commit_pending = pending_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=10, BLANK_CYC=2; cyc counts clock edges since reset release.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [4:0] wr_data = 5'h00;
  logic       commit = 1'b0;
  logic       commit_pending;
  logic       frame_done;
  logic [2:0] cs_pointer;
  logic [4:0] dig_ctrl;
  logic       blank;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif
  localparam logic [7:0] ZERO_MASK = LZ_EN ? 8'h7F : 8'h00;
  localparam logic [7:0] D3_MASK   = LZ_EN ? 8'h07 : 8'h00;

  seg_scan_ctrl #(
    .F_CLK    (1000),
    .F_SCAN   (100),
    .BLANK_CYC(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .commit        (commit),
    .commit_pending(commit_pending),
    .frame_done    (frame_done),
    .cs_pointer    (cs_pointer),
    .dig_ctrl      (dig_ctrl),
    .blank         (blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp)
      n_pass++;
    else
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic write_shadow(input logic [2:0] a, input logic [4:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    $display("cyc=%0d write shadow[%0d]=%02h", cyc, a, d);
  endtask

  task automatic request_commit();
    commit = 1'b1;
    $display("cyc=%0d commit request", cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // Slot timing: 10 cycles per digit, first 2 blanked, frame boundary every 80 cycles.
  task automatic check_cycle(input logic [4:0] exp_dig, input bit exp_pend, input logic [7:0] mask);
    int slot;
    bit exp_blank;
    bit exp_fd;
    slot      = (cyc / 10) % 8;
    exp_blank = ((cyc % 10) < 2) || mask[slot];
    exp_fd    = (cyc > 0) && (cyc % 80 == 0);
    check("cs_pointer", 32'(cs_pointer), 32'(slot));
    check("blank", 32'(blank), 32'(exp_blank));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    check("dig_ctrl", 32'(dig_ctrl), 32'(exp_dig));
    check("commit_pending", 32'(commit_pending), 32'(exp_pend));
  endtask

  // Hand table for the commit/boundary sequence: frame f = c/80, slot s.
  function automatic logic [4:0] bd_dig(input int c);
    int f;
    int s;
    f = c / 80;
    s = (c / 10) % 8;
    if (f == 0) return 5'h00;
    if (f <= 2) return 5'(s + 1);
    if (f <= 4) return 5'(s + 17);
    if (s == 0) return 5'h09;
    return 5'(s + 17);
  endfunction

  function automatic bit bd_pend(input int c);
    return (c >= 21 && c <= 79) || (c >= 160 && c <= 239) ||
           (c >= 261 && c <= 319) || (c >= 331 && c <= 399);
  endfunction

  initial begin
    do_reset();

    // Scan timing from reset, plus an uncommitted write that must never show.
    $display("phase: reset release and uncommitted write");
    while (cyc < 240) begin
      check_cycle(5'h00, 1'b0, ZERO_MASK);
      idle_inputs();
      if (cyc == 5) write_shadow(3'd3, 5'h15);
      step();
    end

    // Commit at a normal time, on a boundary with none pending, and on a boundary with one pending.
    do_reset();
    $display("phase: commit and boundary collisions");
    while (cyc < 420) begin
      check_cycle(bd_dig(cyc), bd_pend(cyc), (cyc < 80) ? ZERO_MASK : 8'h00);
      idle_inputs();
      if (cyc >= 10 && cyc <= 17) write_shadow(3'(cyc - 10), 5'(cyc - 9));
      if (cyc >= 100 && cyc <= 107) write_shadow(3'(cyc - 100), 5'(cyc - 100 + 17));
      if (cyc == 20 || cyc == 159 || cyc == 260 || cyc == 330) request_commit();
      if (cyc == 319) begin
        write_shadow(3'd0, 5'h09);
        request_commit();
      end
      step();
    end

    // Single non-zero digit 3, then an asynchronous reset in the middle of a slot.
    do_reset();
    $display("phase: single digit and mid-frame reset");
    while (cyc <= 195) begin
      check_cycle((cyc >= 80 && (cyc / 10) % 8 == 3) ? 5'h01 : 5'h00,
                  (cyc >= 21 && cyc <= 79) || (cyc >= 191),
                  (cyc < 80) ? ZERO_MASK : D3_MASK);
      if (cyc == 195) break;
      idle_inputs();
      if (cyc == 10) write_shadow(3'd3, 5'h01);
      if (cyc == 20 || cyc == 190) request_commit();
      step();
    end
    rst_n = 1'b0;
    idle_inputs();
    #1;
    $display("reset asserted mid-slot");
    check("rst_cs_pointer", 32'(cs_pointer), 32'd0);
    check("rst_blank", 32'(blank), 32'd1);
    check("rst_dig_ctrl", 32'(dig_ctrl), 32'd0);
    check("rst_commit_pending", 32'(commit_pending), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    // Shadow was cleared by reset, so a fresh commit publishes zeros.
    $display("phase: commit after reset publishes cleared shadow");
    while (cyc < 120) begin
      check_cycle(5'h00, (cyc >= 1 && cyc <= 79), ZERO_MASK);
      idle_inputs();
      if (cyc == 0) request_commit();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
